// File: rtl/rf_write_scheduler_if.sv
// Bundles the writers, reservation/check ports and register-file write port of
// rf_write_scheduler.
//   master : writeback stage, mul/div unit, late-load path, issue logic
//   slave  : the scheduler itself
// Signals:
//   wb_*      pipeline writeback (never refused)
//   md_*      mul/div result request with ack
//   ld_*      late-load request with ack
//   rsv_*     reserve a destination register for a long-latency write
//   chk_*     RAW hazard lookups against the pending scoreboard
//   pending   scoreboard, bit 0 always 0
//   stall     pipeline must hold wb_wr low while set
//   rf_*      register file write port
interface rf_write_scheduler_if;
  logic        wb_wr;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        md_req;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        md_ack;

  logic        ld_req;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_ack;

  logic        rsv_valid;
  logic [4:0]  rsv_addr;

  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        chk_busy1;
  logic        chk_busy2;

  logic [31:0] pending;
  logic        stall;

  logic        rf_wr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  modport master (
    output wb_wr, wb_addr, wb_data,
    output md_req, md_addr, md_data,
    input  md_ack,
    output ld_req, ld_addr, ld_data,
    input  ld_ack,
    output rsv_valid, rsv_addr,
    output chk_addr1, chk_addr2,
    input  chk_busy1, chk_busy2,
    input  pending, stall,
    input  rf_wr, rf_addr, rf_data
  );

  modport slave (
    input  wb_wr, wb_addr, wb_data,
    input  md_req, md_addr, md_data,
    output md_ack,
    input  ld_req, ld_addr, ld_data,
    output ld_ack,
    input  rsv_valid, rsv_addr,
    input  chk_addr1, chk_addr2,
    output chk_busy1, chk_busy2,
    output pending, stall,
    output rf_wr, rf_addr, rf_data
  );
endinterface

// File: rtl/rf_write_scheduler.sv
// Arbitrates the single register-file write port between the pipeline writeback
// stage (absolute priority), the mul/div unit and the late-load path (round-robin
// between the two). Tracks pending long-latency writes for RAW hazard checks and
// raises stall when a long-latency requester has waited STARVE_LIMIT cycles.
// Ports:
//   clk    clock
//   reset  asynchronous reset, active low
//   bus    rf_write_scheduler_if.slave (writers, scoreboard, rf write port)
module rf_write_scheduler #(
  parameter int unsigned STARVE_LIMIT = 4  // legal 1..7
) (
  input logic              clk,
  input logic              reset,
  rf_write_scheduler_if.slave bus
);

  // Which long-latency writer was served most recently.
  typedef enum logic {
    RrMdLast = 1'b0,
    RrLdLast = 1'b1
  } rr_e;

  rr_e         rr_q, rr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:1] pending_q, pending_d;

  logic        grant_wb;
  logic        grant_md;
  logic        grant_ld;
  logic [4:0]  win_addr;
  logic [31:0] win_data;
  logic        rf_wr;
  logic [31:0] pending_full;

  // Grant selection and write-port mux.
  always_comb begin
    grant_wb = 1'b0;
    grant_md = 1'b0;
    grant_ld = 1'b0;
    win_addr = bus.wb_addr;
    win_data = bus.wb_data;

    if (bus.wb_wr) begin
      grant_wb = 1'b1;
    end else if (bus.md_req && bus.ld_req) begin
      if (rr_q == RrLdLast) grant_md = 1'b1;
      else                  grant_ld = 1'b1;
    end else if (bus.md_req) begin
      grant_md = 1'b1;
    end else if (bus.ld_req) begin
      grant_ld = 1'b1;
    end

    // Nothing reaches the register file while reset is asserted.
    if (!reset) begin
      grant_wb = 1'b0;
      grant_md = 1'b0;
      grant_ld = 1'b0;
    end

    if (grant_md) begin
      win_addr = bus.md_addr;
      win_data = bus.md_data;
    end else if (grant_ld) begin
      win_addr = bus.ld_addr;
      win_data = bus.ld_data;
    end

    // Writes to x0 are acked but dropped.
    rf_wr = (grant_wb || grant_md || grant_ld) && (win_addr != 5'd0);
  end

  // Next-state for rr, starvation counter and scoreboard.
  always_comb begin
    rr_d      = rr_q;
    cnt_d     = 3'd0;
    pending_d = pending_q;

    if (grant_md)      rr_d = RrMdLast;
    else if (grant_ld) rr_d = RrLdLast;

    if (grant_md || grant_ld) begin
      cnt_d = 3'd0;
    end else if (bus.md_req || bus.ld_req) begin
      cnt_d = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
    end

    // Set is applied after clear so a same-cycle reserve wins.
    for (int i = 1; i < 32; i++) begin
      if (rf_wr && (win_addr == 5'(i)))                  pending_d[i] = 1'b0;
      if (bus.rsv_valid && (bus.rsv_addr == 5'(i)))      pending_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q      <= RrLdLast;
      cnt_q     <= 3'd0;
      pending_q <= '0;
    end else begin
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending_full  = {pending_q, 1'b0};

  assign bus.md_ack    = grant_md;
  assign bus.ld_ack    = grant_ld;
  assign bus.rf_wr     = rf_wr;
  assign bus.rf_addr   = win_addr;
  assign bus.rf_data   = win_data;
  assign bus.pending   = pending_full;
  // Decoded straight from the counter register so it cannot glitch.
  assign bus.stall     = (cnt_q >= 3'(STARVE_LIMIT));
  assign bus.chk_busy1 = (bus.chk_addr1 != 5'd0) && pending_full[bus.chk_addr1];
  assign bus.chk_busy2 = (bus.chk_addr2 != 5'd0) && pending_full[bus.chk_addr2];

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler. Expected register-file writes are queued
// when stimulus is issued; a negedge monitor pops and compares on every rf_wr.
module tb_rf_write_scheduler;

  localparam int unsigned StarveLimit = 4;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic reset;
  wr_t  exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  rf_write_scheduler_if bus ();

  rf_write_scheduler #(
    .STARVE_LIMIT(StarveLimit)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic idle_inputs();
    bus.wb_wr     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.md_req    = 1'b0;
    bus.md_addr   = '0;
    bus.md_data   = '0;
    bus.ld_req    = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;
    bus.rsv_valid = 1'b0;
    bus.rsv_addr  = '0;
  endtask

  // Step to just after the next active edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (bus.rf_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write (t=%0t)",
                 bus.rf_addr, bus.rf_data, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("rf_addr", 32'(bus.rf_addr), 32'(e.addr));
        chk("rf_data", bus.rf_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    bus.chk_addr1 = 5'd9;
    bus.chk_addr2 = 5'd0;
    reset = 1'b0;
    // Requests during reset must not be granted.
    bus.wb_wr   = 1'b1;
    bus.wb_addr = 5'd4;
    bus.md_req  = 1'b1;
    bus.ld_req  = 1'b1;
    #2;
    chk("rst_md_ack", 32'(bus.md_ack), 32'd0);
    chk("rst_ld_ack", 32'(bus.ld_ack), 32'd0);
    chk("rst_rf_wr", 32'(bus.rf_wr), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_pending", bus.pending, 32'h0);
    idle_inputs();
    #10 reset = 1'b1;

    // Round-robin after reset: md first, then ld.
    next_cycle();
    bus.md_req = 1'b1; bus.md_addr = 5'd5; bus.md_data = 32'hA5A5_0005;
    bus.ld_req = 1'b1; bus.ld_addr = 5'd6; bus.ld_data = 32'h5A5A_0006;
    push(5'd5, 32'hA5A5_0005);
    push(5'd6, 32'h5A5A_0006);
    @(negedge clk);
    chk("rr_c0_md_ack", 32'(bus.md_ack), 32'd1);
    chk("rr_c0_ld_ack", 32'(bus.ld_ack), 32'd0);
    next_cycle();
    bus.md_req = 1'b0;
    @(negedge clk);
    chk("rr_c1_ld_ack", 32'(bus.ld_ack), 32'd1);
    chk("rr_c1_md_ack", 32'(bus.md_ack), 32'd0);
    next_cycle();
    bus.ld_req = 1'b0;

    // Pipeline priority over a waiting mul/div result.
    next_cycle();
    bus.wb_wr  = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h0000_0333;
    bus.md_req = 1'b1; bus.md_addr = 5'd7; bus.md_data = 32'h0000_0777;
    push(5'd3, 32'h0000_0333);
    @(negedge clk);
    chk("prio_rf_addr", 32'(bus.rf_addr), 32'd3);
    chk("prio_md_ack", 32'(bus.md_ack), 32'd0);
    next_cycle();
    bus.wb_wr = 1'b0;
    push(5'd7, 32'h0000_0777);
    @(negedge clk);
    chk("prio_md_ack_late", 32'(bus.md_ack), 32'd1);
    next_cycle();
    bus.md_req = 1'b0;

    // Starvation: stall in cycle 4, obeyed, md granted, stall clears in cycle 5.
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      bus.wb_wr = 1'b1; bus.wb_addr = 5'd10; bus.wb_data = 32'h1000_0000 + 32'(c);
      bus.md_req = 1'b1; bus.md_addr = 5'd11; bus.md_data = 32'h0000_0B11;
      push(5'd10, 32'h1000_0000 + 32'(c));
      @(negedge clk);
      chk("starve_stall_low", 32'(bus.stall), 32'd0);
      chk("starve_md_wait", 32'(bus.md_ack), 32'd0);
    end
    next_cycle();
    chk("starve_stall_c4", 32'(bus.stall), 32'd1);
    bus.wb_wr = 1'b0;
    push(5'd11, 32'h0000_0B11);
    @(negedge clk);
    chk("starve_md_ack_c4", 32'(bus.md_ack), 32'd1);
    next_cycle();
    bus.md_req = 1'b0;
    @(negedge clk);
    chk("starve_stall_c5", 32'(bus.stall), 32'd0);

    // Stall ignored: pipeline still wins, stall holds until the md grant.
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      bus.wb_wr = 1'b1; bus.wb_addr = 5'd15; bus.wb_data = 32'h2000_0000 + 32'(c);
      bus.md_req = 1'b1; bus.md_addr = 5'd16; bus.md_data = 32'h0000_1616;
      push(5'd15, 32'h2000_0000 + 32'(c));
      @(negedge clk);
      chk("viol_stall", 32'(bus.stall), (c >= 4) ? 32'd1 : 32'd0);
      chk("viol_md_ack", 32'(bus.md_ack), 32'd0);
    end
    next_cycle();
    bus.wb_wr = 1'b0;
    push(5'd16, 32'h0000_1616);
    @(negedge clk);
    chk("viol_md_ack_grant", 32'(bus.md_ack), 32'd1);
    chk("viol_stall_held", 32'(bus.stall), 32'd1);
    next_cycle();
    bus.md_req = 1'b0;
    @(negedge clk);
    chk("viol_stall_clear", 32'(bus.stall), 32'd0);

    // Scoreboard reserve / clear / same-cycle set-wins.
    bus.chk_addr2 = 5'd9;
    next_cycle();
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd9;
    @(negedge clk);
    chk("sb_busy_c0", 32'(bus.chk_busy1), 32'd0);
    next_cycle();
    bus.rsv_valid = 1'b0;
    @(negedge clk);
    chk("sb_busy1_c1", 32'(bus.chk_busy1), 32'd1);
    chk("sb_busy2_c1", 32'(bus.chk_busy2), 32'd1);
    chk("sb_pending_c1", bus.pending, 32'h0000_0200);
    next_cycle();
    next_cycle();
    bus.ld_req = 1'b1; bus.ld_addr = 5'd9; bus.ld_data = 32'h0000_0999;
    push(5'd9, 32'h0000_0999);
    @(negedge clk);
    chk("sb_ld_ack_c3", 32'(bus.ld_ack), 32'd1);
    chk("sb_busy_c3", 32'(bus.chk_busy1), 32'd1);
    next_cycle();
    bus.ld_req = 1'b0;
    @(negedge clk);
    chk("sb_busy_c4", 32'(bus.chk_busy1), 32'd0);
    next_cycle();
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd9;
    bus.ld_req = 1'b1; bus.ld_addr = 5'd9; bus.ld_data = 32'h0000_9999;
    push(5'd9, 32'h0000_9999);
    @(negedge clk);
    chk("sb_same_ld_ack", 32'(bus.ld_ack), 32'd1);
    next_cycle();
    bus.rsv_valid = 1'b0;
    bus.ld_req = 1'b0;
    @(negedge clk);
    chk("sb_same_busy", 32'(bus.chk_busy1), 32'd1);
    chk("sb_same_pending", bus.pending, 32'h0000_0200);

    // Register 0: acked but not written; reserve of x0 ignored.
    bus.chk_addr2 = 5'd0;
    next_cycle();
    bus.md_req = 1'b1; bus.md_addr = 5'd0; bus.md_data = 32'hDEAD_0000;
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd0;
    @(negedge clk);
    chk("r0_md_ack", 32'(bus.md_ack), 32'd1);
    chk("r0_rf_wr", 32'(bus.rf_wr), 32'd0);
    chk("r0_busy2", 32'(bus.chk_busy2), 32'd0);
    next_cycle();
    bus.md_req = 1'b0;
    bus.rsv_valid = 1'b0;
    @(negedge clk);
    chk("r0_pending", bus.pending, 32'h0000_0200);

    // Reset mid-operation with pending=0x300 and cnt=3; rr is md-last here.
    next_cycle();
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd8;
    bus.wb_wr = 1'b1; bus.wb_addr = 5'd14; bus.wb_data = 32'h3000_0000;
    bus.md_req = 1'b1; bus.md_addr = 5'd12; bus.md_data = 32'h0000_1212;
    bus.ld_req = 1'b1; bus.ld_addr = 5'd13; bus.ld_data = 32'h0000_1313;
    push(5'd14, 32'h3000_0000);
    next_cycle();
    bus.rsv_valid = 1'b0;
    bus.wb_data = 32'h3000_0001;
    push(5'd14, 32'h3000_0001);
    next_cycle();
    bus.wb_data = 32'h3000_0002;
    push(5'd14, 32'h3000_0002);
    next_cycle();
    #2;
    chk("mid_pending", bus.pending, 32'h0000_0300);
    chk("mid_stall_cnt3", 32'(bus.stall), 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_pending", bus.pending, 32'h0);
    chk("mid_rst_stall", 32'(bus.stall), 32'd0);
    chk("mid_rst_md_ack", 32'(bus.md_ack), 32'd0);
    chk("mid_rst_ld_ack", 32'(bus.ld_ack), 32'd0);
    chk("mid_rst_rf_wr", 32'(bus.rf_wr), 32'd0);
    bus.wb_wr = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    push(5'd12, 32'h0000_1212);
    push(5'd13, 32'h0000_1313);
    @(negedge clk);
    chk("post_rst_md_ack", 32'(bus.md_ack), 32'd1);
    chk("post_rst_ld_ack", 32'(bus.ld_ack), 32'd0);
    next_cycle();
    bus.md_req = 1'b0;
    @(negedge clk);
    chk("post_rst_ld_ack2", 32'(bus.ld_ack), 32'd1);
    next_cycle();
    bus.ld_req = 1'b0;

    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
